irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that consumes the accelerator completion flags (factorial done, FP multiply done, spare sources) produced by the SoC peripheral fabric. It synchronizes each source, captures rising edges into sticky pending bits, masks them, and presents a single interrupt line plus a prioritized cause to the processor. It occupies one 16-byte slot on the SoC bus: a decoder write-enable, with read data returned through the SoC output mux.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_ctrl_sync_edge.sv | 27 ++
 rtl/irq_ctrl.sv | 85 ++++++++
 tb/tb_irq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register map, field widths and priority helper for irq_ctrl
package irq_pkg;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_CAUSE   = 2'd2,
        REG_COUNT   = 2'd3
    } reg_addr_e;

    localparam int CAUSE_VALID_BIT = 31;
    localparam int COUNT_W         = 8;
    localparam int IRQ_ID_W        = 4;
    localparam int N_SRC_MAX       = 16;

    // Scanning downward leaves the lowest set index, i.e. the highest priority.
    function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [N_SRC_MAX-1:0] v);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// rtl/irq_ctrl_sync_edge.sv - 2-flop synchronizer plus previous-value flop, emits a rise pulse
module sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - sticky edge-captured interrupt controller with enable mask, cause and edge counter
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    src,
    input  logic                we,
    input  logic [1:0]          a,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    output logic                irq,
    output logic [IRQ_ID_W-1:0] irq_id
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [N_SRC-1:0]     w_rise;
    logic [N_SRC-1:0]     w_clr;
    logic [N_SRC-1:0]     w_active;
    logic [N_SRC_MAX-1:0] w_active_ext;
    logic                 w_unused;

    logic [N_SRC-1:0]     r_pending;
    logic [N_SRC-1:0]     r_enable;
    logic [COUNT_W-1:0]   r_count;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        sync_edge u_sync (
            .i_clk   (clk),
            .i_reset (reset),
            .i_d     (src[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_clr    = (we && a == REG_PENDING) ? wd[N_SRC-1:0] : '0;
    assign w_unused = ^wd[31:N_SRC];

    // OR-ing the rise after the clear lets a fresh edge survive a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (we && a == REG_ENABLE) begin
                r_enable <= wd[N_SRC-1:0];
            end
            if (we && a == REG_COUNT) begin
                r_count <= '0;
            end else if ((|w_rise) && r_count != COUNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign w_active = r_pending & r_enable;

    always_comb begin
        w_active_ext              = '0;
        w_active_ext[N_SRC-1:0]   = w_active;
    end

    assign irq    = |w_active;
    assign irq_id = lowest_set(w_active_ext);

    always_comb begin
        rd = '0;
        case (reg_addr_e'(a))
            REG_PENDING: rd[N_SRC-1:0] = r_pending;
            REG_ENABLE:  rd[N_SRC-1:0] = r_enable;
            REG_CAUSE: begin
                rd[CAUSE_VALID_BIT]  = irq;
                rd[IRQ_ID_W-1:0]     = irq_id;
            end
            REG_COUNT:   rd[COUNT_W-1:0] = r_count;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed and randomized self-checking bench for irq_ctrl
module tb_irq_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src;
    logic          we;
    logic [1:0]    a;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          irq;
    logic [3:0]    irq_id;

    int n_assert = 0;
    int n_fail   = 0;

    // reference state: register contents plus the recent edge history of src
    logic [N-1:0]  m_pending, m_enable;
    int            m_count;
    logic [N-1:0]  m_last_src, m_edge_d1, m_edge_d2;

    logic [31:0]   obs_rd [4];
    logic          obs_irq;
    logic [3:0]    obs_id;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .src    (src),
        .we     (we),
        .a      (a),
        .wd     (wd),
        .rd     (rd),
        .irq    (irq),
        .irq_id (irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_reg(input int ai);
        logic [N-1:0] act;
        act = m_pending & m_enable;
        case (ai)
            0: return 32'(m_pending);
            1: return 32'(m_enable);
            2: return (act != 0) ? (32'h8000_0000 | 32'(lowest_index(act))) : 32'h0;
            default: return 32'(m_count);
        endcase
    endfunction

    task automatic model_reset();
        m_pending  = '0;
        m_enable   = '0;
        m_count    = 0;
        m_last_src = '0;
        m_edge_d1  = '0;
        m_edge_d2  = '0;
    endtask

    // A 0->1 change of src seen at clock edge n lands in pending at edge n+2.
    task automatic model_edge();
        logic [N-1:0] arrived;
        arrived    = m_edge_d2;
        m_edge_d2  = m_edge_d1;
        m_edge_d1  = src & ~m_last_src;
        m_last_src = src;
        if (we && a == 2'd0) m_pending = m_pending & ~wd[N-1:0];
        m_pending = m_pending | arrived;
        if (we && a == 2'd1) m_enable = wd[N-1:0];
        if (we && a == 2'd3) m_count = 0;
        else if (arrived != 0 && m_count < 255) m_count = m_count + 1;
    endtask

    task automatic check_all();
        logic [N-1:0] act;
        we = 1'b0;
        for (int ai = 0; ai < 4; ai++) begin
            a = 2'(ai);
            #1;
            obs_rd[ai] = rd;
            chk($sformatf("rd[a=%0d]", ai), rd, exp_reg(ai));
        end
        obs_irq = irq;
        obs_id  = irq_id;
        act = m_pending & m_enable;
        chk("irq", 32'(irq), 32'(act != 0));
        chk("irq_id", 32'(irq_id), 32'(lowest_index(act)));
    endtask

    task automatic step(input logic [N-1:0] s, input logic w, input logic [1:0] av, input logic [31:0] d);
        src = s;
        we  = w;
        a   = av;
        wd  = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic [N-1:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        src   = '0;
        we    = 1'b0;
        a     = 2'd0;
        wd    = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        chk("reset_pending", obs_rd[0], 32'h0);
        chk("reset_enable",  obs_rd[1], 32'h0);
        chk("reset_cause",   obs_rd[2], 32'h0);
        chk("reset_count",   obs_rd[3], 32'h0);
        chk("reset_irq",     32'(obs_irq), 32'h0);
        reset = 1'b0;

        // single source, enabled
        step('0, 1'b1, 2'd1, 32'h3);
        idle(4'h2, 3);
        chk("t1_pending", obs_rd[0], 32'h2);
        chk("t1_cause",   obs_rd[2], 32'h8000_0001);
        chk("t1_count",   obs_rd[3], 32'h1);
        step(4'h2, 1'b1, 2'd0, 32'h2);
        chk("t1_w1c_pending", obs_rd[0], 32'h0);
        chk("t1_w1c_irq",     32'(obs_irq), 32'h0);
        idle('0, 3);

        // two simultaneous edges, priority and count-once
        step('0, 1'b1, 2'd1, 32'hF);
        step('0, 1'b1, 2'd3, 32'h0);
        idle(4'h5, 3);
        chk("t2_pending", obs_rd[0], 32'h5);
        chk("t2_id",      32'(obs_id), 32'h0);
        chk("t2_count",   obs_rd[3], 32'h1);
        step(4'h5, 1'b1, 2'd0, 32'h1);
        chk("t2_id_after", 32'(obs_id), 32'h2);
        chk("t2_cause",    obs_rd[2], 32'h8000_0002);
        idle('0, 3);
        step('0, 1'b1, 2'd0, 32'hF);

        // pending captured while disabled, irq appears on enable
        step('0, 1'b1, 2'd1, 32'h0);
        idle(4'h8, 3);
        chk("t3_pending", obs_rd[0], 32'h8);
        chk("t3_irq_off", 32'(obs_irq), 32'h0);
        step(4'h8, 1'b1, 2'd1, 32'h8);
        chk("t3_irq_on", 32'(obs_irq), 32'h1);
        chk("t3_id",     32'(obs_id), 32'h3);
        idle('0, 3);
        step('0, 1'b1, 2'd0, 32'hF);

        // W1C colliding with a new rise: set wins
        idle(4'h1, 2);
        step(4'h1, 1'b1, 2'd0, 32'h1);
        chk("t4_set_wins", obs_rd[0] & 32'h1, 32'h1);
        idle('0, 2);
        // COUNT clear colliding with a rise: clear wins
        idle(4'h1, 2);
        step(4'h1, 1'b1, 2'd3, 32'h0);
        chk("t4_count_clear", obs_rd[3], 32'h0);
        // saturation
        for (int i = 0; i < 300; i++) begin
            step(4'h1, 1'b0, 2'd0, 32'h0);
            step(4'h0, 1'b0, 2'd0, 32'h0);
        end
        idle('0, 2);
        chk("t4_count_sat", obs_rd[3], 32'd255);

        // asynchronous reset mid-operation with a source held high
        idle(4'h1, 3);
        #2;
        reset = 1'b1;
        model_reset();
        check_all();
        chk("t5_rst_pending", obs_rd[0], 32'h0);
        chk("t5_rst_count",   obs_rd[3], 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(4'h1, 2);
        chk("t5_not_yet", obs_rd[0], 32'h0);
        idle(4'h1, 1);
        chk("t5_pending", obs_rd[0], 32'h1);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), ($urandom_range(3) == 0), 2'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
